uart_rx: RTL



---
 rtl/uart_rx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first.
//
// Bit period P = baudrate_div + 1 clocks, the same convention as the
// companion transmitter. The asynchronous line is double-flopped. A start
// edge is confirmed half a bit later, each data bit is sampled at its
// centre, and the stop bit is checked at its centre. Each good byte is
// offered through a one-entry valid/ready holding register.
//
// Ports:
//   clk            system clock (12 MHz)
//   rst_n          asynchronous active-low reset (deassertion synchronised inside)
//   baudrate_div   bit period minus one, in clocks (>= 3, static during a frame)
//   uart_rxd       serial input, asynchronous, idles high
//   rx_data        received byte, meaningful while rx_valid is high
//   rx_valid       holding register full
//   rx_ready       consumer accepts; a transfer is rx_valid && rx_ready
//   rx_framing_err one-cycle pulse: stop bit sampled low
//   rx_overrun     one-cycle pulse: byte completed while holding register full and not read
module uart_rx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] baudrate_div,
   input  logic        uart_rxd,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        rx_framing_err,
   output logic        rx_overrun
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;

   // Reset asserts immediately but releases on a clock edge, so no flop
   // sees a reset removal close to its sampling edge.
   logic [1:0] rst_sync_reg;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_reg <= 2'b00;
      else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end

   assign rst_int_n = rst_sync_reg[1];

   logic [1:0]  sync_reg;
   logic        rxd_s;
   logic [2:0]  state_reg, state_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [2:0]  bit_cnt_reg, bit_cnt_next;
   logic [7:0]  shift_reg, shift_next;
   logic        done_reg, done_next;
   logic        ferr_next;
   logic        counting;
   logic        tick;

   assign rxd_s    = sync_reg[1];
   assign counting = (state_reg == ST_START) || (state_reg == ST_DATA) || (state_reg == ST_STOP);
   assign tick     = counting && (cnt_reg == 16'd0);

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      done_next    = 1'b0;
      ferr_next    = 1'b0;

      if (counting && !tick) cnt_next = cnt_reg - 16'd1;

      case (state_reg)
         ST_IDLE: begin
            // Half a period to reach the centre of the start bit.
            if (!rxd_s) begin
               cnt_next   = baudrate_div >> 1;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               if (rxd_s) begin
                  // Line went back high before mid-bit: glitch, not a start.
                  cnt_next   = 16'd0;
                  state_next = ST_IDLE;
               end else begin
                  cnt_next     = baudrate_div;
                  bit_cnt_next = 3'd0;
                  state_next   = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_next   = {rxd_s, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               cnt_next     = baudrate_div;
               if (bit_cnt_reg == 3'd7) state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            // Leave at mid-stop-bit so the next start edge is seen on time.
            if (tick) begin
               cnt_next   = 16'd0;
               done_next  = rxd_s;
               ferr_next  = !rxd_s;
               state_next = rxd_s ? ST_IDLE : ST_BREAK;
            end
         end
         ST_BREAK: begin
            // One framing error per low period, however long the break.
            if (rxd_s) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         sync_reg       <= 2'b11;
         state_reg      <= ST_IDLE;
         cnt_reg        <= 16'd0;
         bit_cnt_reg    <= 3'd0;
         shift_reg      <= 8'h00;
         done_reg       <= 1'b0;
         rx_data        <= 8'h00;
         rx_valid       <= 1'b0;
         rx_framing_err <= 1'b0;
         rx_overrun     <= 1'b0;
      end else begin
         sync_reg       <= {sync_reg[0], uart_rxd};
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         bit_cnt_reg    <= bit_cnt_next;
         shift_reg      <= shift_next;
         done_reg       <= done_next;
         rx_framing_err <= ferr_next;
         rx_overrun     <= 1'b0;

         // shift_reg still holds the finished byte here: IDLE never shifts.
         if (done_reg) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift_reg;
               rx_valid <= 1'b1;
            end else begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
